// File: rtl/chip8_sprite_engine.sv
// chip8_sprite_engine
//   DXYN sprite-draw coprocessor. On start it latches the sprite origin and
//   base address. It then fetches the sprite bytes one at a time and XORs each
//   byte, MSB first, into a flat framebuffer. It reports whether any lit pixel
//   was erased, which the CPU writes into VF. A clear request zeroes the
//   framebuffer (00E0).
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   start, clear          one-cycle requests, honoured only when idle
//   x_in, y_in            sprite origin (VX, VY), masked to the display size
//   n_in                  row count N (0 selects 16x16 when SPRITE16 = 1)
//   i_in                  sprite base address (I)
//   mem_read, mem_addr_out, mem_data_in
//                         byte fetch; data is valid the cycle after mem_read
//   busy                  high while fetching/plotting
//   done                  one-cycle completion pulse
//   collision             1 if the last draw erased a lit pixel
//   display               framebuffer, pixel (x,y) at bit y*DISP_W+x
module chip8_sprite_engine #(
    parameter int DISP_W    = 64,
    parameter int DISP_H    = 32,
    parameter int WRAP_MODE = 0,
    parameter int SPRITE16  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       clear,
    input  logic [7:0]                 x_in,
    input  logic [7:0]                 y_in,
    input  logic [3:0]                 n_in,
    input  logic [11:0]                i_in,
    output logic                       mem_read,
    output logic [11:0]                mem_addr_out,
    input  logic [7:0]                 mem_data_in,
    output logic                       busy,
    output logic                       done,
    output logic                       collision,
    output logic [DISP_W*DISP_H-1:0]   display
);

    localparam int XW   = $clog2(DISP_W);
    localparam int YW   = $clog2(DISP_H);
    localparam int PW   = XW + YW;
    localparam int NPIX = DISP_W * DISP_H;
    localparam logic [7:0] X_MASK = 8'(DISP_W - 1);
    localparam logic [7:0] Y_MASK = 8'(DISP_H - 1);

    // A clear finishes on the cycle after it is sampled, so the framebuffer is
    // zeroed on the sampling edge and the FSM goes straight to S_DONE.
    typedef enum logic [1:0] {S_IDLE, S_RD, S_PLOT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        x0_q, x0_d;
    logic [7:0]        y0_q, y0_d;
    logic [5:0]        count_q, count_d;     // bytes in this sprite (1..32)
    logic [5:0]        idx_q, idx_d;         // byte currently fetched/plotted
    logic              wide_q, wide_d;       // 16-pixel rows, 2 bytes per row
    logic [11:0]       addr_q, addr_d;
    logic [NPIX-1:0]   display_q, display_d;
    logic              collision_q, collision_d;

    logic [5:0]        start_bytes;
    logic [5:0]        row;
    logic [7:0]        col_base;
    logic [7:0]        py_raw;
    logic [7:0]        px_raw;
    logic              y_ok;
    logic [PW-1:0]     pix;
    logic [NPIX-1:0]   plot_d;
    logic              erase;

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        count_d     = count_q;
        idx_d       = idx_q;
        wide_d      = wide_q;
        addr_d      = addr_q;
        display_d   = display_q;
        collision_d = collision_q;
        mem_read    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        if (n_in != 4'd0)       start_bytes = {2'b00, n_in};
        else if (SPRITE16 != 0) start_bytes = 6'd32;
        else                    start_bytes = 6'd0;

        // Pixel coordinates of the byte being plotted. Both display sizes are
        // powers of two, so concatenating the low coordinate bits gives the
        // flat index and, in wrap mode, the modulo for free.
        row      = wide_q ? {1'b0, idx_q[5:1]} : idx_q;
        col_base = x0_q + ((wide_q && idx_q[0]) ? 8'd8 : 8'd0);
        py_raw   = y0_q + {2'b00, row};
        y_ok     = (WRAP_MODE != 0) || ((py_raw >> YW) == 8'd0);
        px_raw   = col_base;
        pix      = '0;
        erase    = 1'b0;
        plot_d   = display_q;
        // NOTE: blocking assignments here are deliberate; each pixel update
        // reads the result of the previous one within the same evaluation.
        for (int c = 0; c < 8; c++) begin
            px_raw = col_base + 8'(c);
            pix    = {py_raw[YW-1:0], px_raw[XW-1:0]};
            if (mem_data_in[3'(7 - c)] && y_ok &&
                ((WRAP_MODE != 0) || ((px_raw >> XW) == 8'd0))) begin
                erase       = erase | plot_d[pix];
                plot_d[pix] = ~plot_d[pix];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    display_d   = '0;
                    collision_d = 1'b0;
                    state_d     = S_DONE;
                end else if (start) begin
                    x0_d        = x_in & X_MASK;
                    y0_d        = y_in & Y_MASK;
                    count_d     = start_bytes;
                    idx_d       = 6'd0;
                    wide_d      = (n_in == 4'd0);
                    collision_d = 1'b0;
                    if (start_bytes == 6'd0) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = i_in;
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                state_d  = S_PLOT;
            end
            S_PLOT: begin
                busy        = 1'b1;
                display_d   = plot_d;
                collision_d = collision_q | erase;
                if (idx_q == count_q - 6'd1) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    addr_d  = addr_q + 12'd1;   // wraps modulo 4096
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge. The framebuffer is reset like
    // any other register because it must read back as all zeros after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            wide_q      <= 1'b0;
            addr_q      <= '0;
            display_q   <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            wide_q      <= wide_d;
            addr_q      <= addr_d;
            display_q   <= display_d;
            collision_q <= collision_d;
        end
    end

    assign mem_addr_out = addr_q;
    assign collision    = collision_q;
    assign display      = display_q;

endmodule

// File: tb/tb_chip8_sprite_engine.sv
// Bench for chip8_sprite_engine. Two instances share all inputs:
//   dut_a: 64x32, clip edges, SPRITE16 = 1
//   dut_b: 64x32, wrap edges, SPRITE16 = 0
// Each instance has its own copy of the sprite memory read port. A 2-D pixel
// model per instance tracks the expected framebuffer and collision flag.
module tb_chip8_sprite_engine;

    localparam int W       = 64;
    localparam int H       = 32;
    localparam int NO_POKE = -10;

    logic            clk = 1'b0;
    logic            rst;
    logic            start, clear;
    logic [7:0]      x_in, y_in;
    logic [3:0]      n_in;
    logic [11:0]     i_in;
    logic            mem_read_a, mem_read_b;
    logic [11:0]     mem_addr_a, mem_addr_b;
    logic [7:0]      mem_data_a, mem_data_b;
    logic            busy_a, busy_b, done_a, done_b, coll_a, coll_b;
    logic [W*H-1:0]  disp_a, disp_b;

    always #5 clk = ~clk;

    chip8_sprite_engine #(.DISP_W(W), .DISP_H(H), .WRAP_MODE(0), .SPRITE16(1)) dut_a (
        .clk(clk), .reset(rst), .start(start), .clear(clear),
        .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
        .mem_read(mem_read_a), .mem_addr_out(mem_addr_a), .mem_data_in(mem_data_a),
        .busy(busy_a), .done(done_a), .collision(coll_a), .display(disp_a)
    );

    chip8_sprite_engine #(.DISP_W(W), .DISP_H(H), .WRAP_MODE(1), .SPRITE16(0)) dut_b (
        .clk(clk), .reset(rst), .start(start), .clear(clear),
        .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
        .mem_read(mem_read_b), .mem_addr_out(mem_addr_b), .mem_data_in(mem_data_b),
        .busy(busy_b), .done(done_b), .collision(coll_b), .display(disp_b)
    );

    // Sprite memory: one-cycle read latency.
    logic [7:0] mem [0:4095];
    always @(posedge clk) begin
        mem_data_a <= mem[mem_addr_a];
        mem_data_b <= mem[mem_addr_b];
    end

    // Read monitor: counts mem_read cycles and logs their addresses.
    int          rd_cnt [2];
    logic [11:0] rd_log [0:1][0:1023];
    always @(negedge clk) begin
        if (mem_read_a === 1'b1) begin
            rd_log[0][rd_cnt[0] % 1024] <= mem_addr_a;
            rd_cnt[0] <= rd_cnt[0] + 1;
        end
        if (mem_read_b === 1'b1) begin
            rd_log[1][rd_cnt[1] % 1024] <= mem_addr_b;
            rd_cnt[1] <= rd_cnt[1] + 1;
        end
    end

    // Reference model: one 2-D pixel grid and collision flag per instance.
    bit fb [2][H][W];
    bit mcoll [2];
    int tests = 0;
    int fails = 0;
    int last_dc [2];
    int last_rd [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear(input int d);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                fb[d][y][x] = 1'b0;
        mcoll[d] = 1'b0;
    endtask

    // Straight from the DXYN rules: B rows of 8 (or 16) pixels, MSB leftmost,
    // clip or wrap at the edges, XOR, flag any 1 -> 0 change.
    task automatic model_draw(input int d, input logic [7:0] x, input logic [7:0] y,
                              input logic [3:0] n, input logic [11:0] i);
        int rows, cols, x0, y0, px, py, addr;
        logic [7:0] b;
        bit wrap, s16;
        wrap = (d == 1);
        s16  = (d == 0);
        x0 = int'(x) % W;
        y0 = int'(y) % H;
        rows = (n != 0) ? int'(n) : (s16 ? 16 : 0);
        cols = (n == 0 && s16) ? 16 : 8;
        mcoll[d] = 1'b0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                addr = (int'(i) + r * (cols / 8) + c / 8) % 4096;
                b = mem[addr];
                if (((int'(b) >> (7 - c % 8)) & 1) != 0) begin
                    px = x0 + c;
                    py = y0 + r;
                    if (wrap) begin
                        px = px % W;
                        py = py % H;
                    end
                    if (px < W && py < H) begin
                        if (fb[d][py][px]) mcoll[d] = 1'b1;
                        fb[d][py][px] = !fb[d][py][px];
                    end
                end
            end
        end
    endtask

    function automatic int disp_mism(input int d);
        int m = 0;
        logic p;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                p = (d == 0) ? disp_a[y*W + x] : disp_b[y*W + x];
                if (p !== fb[d][y][x]) m++;
            end
        end
        return m;
    endfunction

    // kind: 0 = draw, 1 = clear, 2 = clear and start together.
    // poke: cycle at which start (with altered inputs) is pulsed mid-draw,
    // followed by clear on the next cycle.
    task automatic do_op(input int kind, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [11:0] i,
                         input int poke, input string tag);
        int base [2];
        int cyc, bytes, exp_dc, mism;
        logic b1 [2];
        string dn;
        @(negedge clk);
        base[0] = rd_cnt[0];
        base[1] = rd_cnt[1];
        x_in = x; y_in = y; n_in = n; i_in = i;
        start = (kind != 1);
        clear = (kind != 0);
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        cyc = 1;
        b1[0] = busy_a;
        b1[1] = busy_b;
        last_dc[0] = -1;
        last_dc[1] = -1;
        while (cyc <= 100 && (last_dc[0] < 0 || last_dc[1] < 0)) begin
            if (done_a === 1'b1 && last_dc[0] < 0) last_dc[0] = cyc;
            if (done_b === 1'b1 && last_dc[1] < 0) last_dc[1] = cyc;
            if (last_dc[0] < 0 || last_dc[1] < 0) begin
                if (cyc == poke) begin
                    start = 1'b1;
                    x_in  = x + 8'd30;
                    n_in  = n + 4'd1;
                    i_in  = i + 12'h100;
                end
                clear = (cyc == poke + 1);
                @(negedge clk);
                cyc++;
                start = 1'b0;
                clear = 1'b0;
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            dn = (d == 0) ? "a" : "b";
            if (kind == 0) model_draw(d, x, y, n, i);
            else           model_clear(d);
            bytes  = (kind != 0) ? 0 : ((n != 0) ? int'(n) : ((d == 0) ? 32 : 0));
            exp_dc = (kind != 0) ? 1 : 2 * bytes + 1;
            last_rd[d] = rd_cnt[d] - base[d];
            check($sformatf("%s %s done_cycle", tag, dn), last_dc[d], exp_dc);
            check($sformatf("%s %s busy_c1", tag, dn), b1[d], bytes > 0);
            check($sformatf("%s %s reads", tag, dn), last_rd[d], bytes);
            if (bytes > 0) begin
                mism = 0;
                for (int k = 0; k < bytes; k++)
                    if (rd_log[d][(base[d] + k) % 1024] !== 12'((int'(i) + k) % 4096)) mism++;
                check($sformatf("%s %s addr_seq_mismatches", tag, dn), mism, 0);
            end
            check($sformatf("%s %s display_mismatches", tag, dn), disp_mism(d), 0);
            check($sformatf("%s %s collision", tag, dn), (d == 0) ? coll_a : coll_b, mcoll[d]);
        end
    endtask

    typedef struct {
        bit          clr;
        logic [7:0]  x, y;
        logic [3:0]  n;
        logic [11:0] i;
        int          done_a, done_b, reads_a, reads_b, pop_a, pop_b;
        bit          coll_a, coll_b;
    } vec_t;

    vec_t vecs [11];

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0;
        x_in = '0; y_in = '0; n_in = '0; i_in = '0;

        for (int k = 0; k < 4096; k++) mem[k] = 8'($urandom);
        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
        mem[12'h100] = 8'hFF; mem[12'h101] = 8'hFF;
        for (int k = 0; k < 32; k++) mem[12'h200 + k] = 8'hFF;
        mem[12'hFFE] = 8'h81; mem[12'hFFF] = 8'h42;
        mem[12'h000] = 8'h24; mem[12'h001] = 8'h18;

        //         clr  x      y      n     i        dA  dB  rA  rB  popA popB cA cB
        vecs[0]  = '{1'b1, 8'd0,   8'd0,  4'd0, 12'h000, 1,  1,  0,  0,  0,   0,   0, 0};
        vecs[1]  = '{1'b0, 8'd0,   8'd0,  4'd5, 12'h050, 11, 11, 5,  5,  14,  14,  0, 0};
        vecs[2]  = '{1'b0, 8'd0,   8'd0,  4'd5, 12'h050, 11, 11, 5,  5,  0,   0,   1, 1};
        vecs[3]  = '{1'b0, 8'd60,  8'd31, 4'd2, 12'h100, 5,  5,  2,  2,  4,   16,  0, 0};
        vecs[4]  = '{1'b1, 8'd0,   8'd0,  4'd0, 12'h000, 1,  1,  0,  0,  0,   0,   0, 0};
        vecs[5]  = '{1'b0, 8'd200, 8'd40, 4'd5, 12'h050, 11, 11, 5,  5,  14,  14,  0, 0};
        vecs[6]  = '{1'b0, 8'd0,   8'd0,  4'd0, 12'h200, 65, 1,  32, 0,  242, 14,  1, 0};
        vecs[7]  = '{1'b1, 8'd0,   8'd0,  4'd0, 12'h000, 1,  1,  0,  0,  0,   0,   0, 0};
        vecs[8]  = '{1'b0, 8'd56,  8'd24, 4'd0, 12'h200, 65, 1,  32, 0,  64,  0,   0, 0};
        vecs[9]  = '{1'b1, 8'd0,   8'd0,  4'd0, 12'h000, 1,  1,  0,  0,  0,   0,   0, 0};
        vecs[10] = '{1'b0, 8'd0,   8'd0,  4'd4, 12'hFFE, 9,  9,  4,  4,  8,   8,   0, 0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst pop_a", $countones(disp_a), 0);
        check("rst pop_b", $countones(disp_b), 0);
        check("rst busy_a", busy_a, 0);
        check("rst done_a", done_a, 0);
        check("rst coll_a", coll_a, 0);
        check("rst mem_read_a", mem_read_a, 0);
        check("rst mem_addr_a", mem_addr_a, 0);
        check("rst busy_b", busy_b, 0);
        rst = 1'b0;
        model_clear(0);
        model_clear(1);

        // Directed table.
        for (int v = 0; v < 11; v++) begin
            do_op(vecs[v].clr ? 1 : 0, vecs[v].x, vecs[v].y, vecs[v].n, vecs[v].i,
                  NO_POKE, $sformatf("vec%0d", v));
            check($sformatf("vec%0d tbl done_a", v), last_dc[0], vecs[v].done_a);
            check($sformatf("vec%0d tbl done_b", v), last_dc[1], vecs[v].done_b);
            check($sformatf("vec%0d tbl reads_a", v), last_rd[0], vecs[v].reads_a);
            check($sformatf("vec%0d tbl reads_b", v), last_rd[1], vecs[v].reads_b);
            check($sformatf("vec%0d tbl pop_a", v), $countones(disp_a), vecs[v].pop_a);
            check($sformatf("vec%0d tbl pop_b", v), $countones(disp_b), vecs[v].pop_b);
            check($sformatf("vec%0d tbl coll_a", v), coll_a, vecs[v].coll_a);
            check($sformatf("vec%0d tbl coll_b", v), coll_b, vecs[v].coll_b);
        end

        // start and clear pulsed (with new inputs) mid-draw are ignored.
        do_op(1, 8'd0, 8'd0, 4'd0, 12'h000, NO_POKE, "pre_poke");
        do_op(0, 8'd0, 8'd0, 4'd5, 12'h050, 3, "poke");
        check("poke pop_a", $countones(disp_a), 14);

        // clear and start in the same cycle: clear wins, no reads.
        do_op(2, 8'd0, 8'd0, 4'd5, 12'h050, NO_POKE, "clr_start");
        check("clr_start pop_a", $countones(disp_a), 0);
        check("clr_start pop_b", $countones(disp_b), 0);

        // Reset in cycle 3 of a draw that has already erased row 0.
        do_op(0, 8'd0, 8'd0, 4'd5, 12'h050, NO_POKE, "pre_rst");
        @(negedge clk);
        x_in = 8'd0; y_in = 8'd0; n_in = 4'd5; i_in = 12'h050;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid coll_a", coll_a, 1);
        rst = 1'b1;
        #1;
        check("midrst pop_a", $countones(disp_a), 0);
        check("midrst pop_b", $countones(disp_b), 0);
        check("midrst busy_a", busy_a, 0);
        check("midrst done_a", done_a, 0);
        check("midrst coll_a", coll_a, 0);
        check("midrst coll_b", coll_b, 0);
        check("midrst mem_addr_a", mem_addr_a, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear(0);
        model_clear(1);
        do_op(0, 8'd0, 8'd0, 4'd5, 12'h050, NO_POKE, "post_rst");
        check("post_rst pop_a", $countones(disp_a), 14);

        // Randomized draws against the pixel model.
        for (int k = 0; k < 40; k++) begin
            do_op((k % 8 == 7) ? 1 : 0, 8'($urandom), 8'($urandom),
                  4'($urandom_range(0, 15)), 12'($urandom), NO_POKE,
                  $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
